hps_pitch_scheduler: RTL
========================

# hps_pitch_scheduler

Frame-level controller that sits between the FFT magnitude stream and `harmonic_product_spectrum`. It admits whole 1024-bin frames into the HPS only when the HPS is free, and discards the frames that arrive while the HPS is busy. It collects the 32 HPS products and emits the winning bin index and its product as a single pitch result. This keeps the HPS frame-aligned and out of its stalled-input state during normal operation.

## Interface
Parameters:
- `DATA_WIDTH`, 24: FFT magnitude width.
- `PRODUCT_WIDTH`, 48: HPS product width.
- `FRAME_LEN`, 1024: bins per FFT frame (power of two).
- `NUM_HPS`, 32: HPS products per frame.
- `BIN_OFFSET`, 2: bin index of the first HPS product.

Ports:
- `clk` in 1: single clock; every flop is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset. The HPS reset is driven from the same source.
- `enable` in 1: admit new frames. Sampled only on frame-start beats.
- `fft_in` Axis_If.Slave, `DATA_WIDTH`: magnitude stream. Frames are delimited by count only.
- `hps_out` Axis_If.Master, `DATA_WIDTH`: to HPS `din`.
- `hps_in` Axis_If.Slave, `PRODUCT_WIDTH`: from HPS `dout`.
- `pitch` Axis_If.Master, `PRODUCT_WIDTH+6`: `{peak_product, bin[5:0]}`.
- `busy` out 1: high when the state is not IDLE.
- `frames_dropped` out 16: saturating count of admitted-eligible frames discarded while busy.

## Operation
- `in_count` (log2 `FRAME_LEN` bits) advances on every `fft_in` handshake in every state and wraps at `FRAME_LEN`. A beat with `in_count==0` is a frame start.
- States: IDLE, PASS, COLLECT, EMIT.
- IDLE:
  - On a frame-start beat with `enable=1`, the frame is forwarded: `hps_out.valid=fft_in.valid`, `fft_in.ready=hps_out.ready`, `hps_out.data=fft_in.data`. The handshake moves the state to PASS.
  - Any other beat is accepted and discarded: `fft_in.ready=1`, `hps_out.valid=0`. This covers mid-frame beats and frame starts with `enable=0`.
- PASS:
  - Combinational pass-through with the same wiring as the forwarding beat.
  - The handshake with `in_count==FRAME_LEN-1` moves the state to COLLECT.
- COLLECT:
  - `hps_in.ready=1`; `k` (5 bits) counts products.
  - On `k==0`, `max_val` is loaded with the product and `max_idx` with 0.
  - On later products, a product strictly greater than `max_val` replaces it and sets `max_idx=k`. Ties keep the lower bin.
  - The handshake with `k==NUM_HPS-1` updates max using that product, then moves the state to EMIT.
- EMIT:
  - `pitch.valid=1`, `pitch.data={max_val, max_idx+BIN_OFFSET}`. The result is held stable until `pitch.ready`.
  - The handshake moves the state to IDLE.
- In PASS, COLLECT and EMIT, `fft_in` beats that are not part of the forwarded frame are accepted and discarded (`fft_in.ready=1`).
- In COLLECT and EMIT, a frame-start beat with `enable=1` increments `frames_dropped`, saturating at 0xFFFF. A frame start with `enable=0` is never counted.
- `hps_in.ready=0` outside COLLECT. `hps_out.valid=0` outside PASS and the IDLE forwarding beat.

## Timing
- Reset values:
  - State IDLE; `in_count`, `k`, `max_val`, `max_idx` = 0; `frames_dropped` = 0.
  - `pitch.valid=0`, `busy=0`, `hps_out.valid=0`, `hps_in.ready=0`.
  - `fft_in.ready=1`. This follows from IDLE discard: it tracks `hps_out.ready` only while `enable=1` and `fft_in.valid` is asserted with `in_count==0`; otherwise it is 1.
- The forwarding path has zero latency; `valid`, `ready` and `data` are combinational through the block.
- `pitch.valid` rises in the cycle after the last `hps_in` handshake. IDLE is re-entered in the cycle after the `pitch` handshake.
- A frame start arriving in the same cycle as the EMIT→IDLE transition is seen in EMIT, so it is discarded and counted. Admission requires the state to be IDLE at that beat.
- Asserting `reset_n` low mid-frame clears all state immediately. After release, the next `fft_in` beat is treated as a frame start.
- Backpressure on `hps_out` stalls `fft_in` during forwarding. No beat may be lost or duplicated.

## Test plan
- Single frame, `enable=1`, model HPS products with the maximum at k=7 (0x00_1234_5678) → all 1024 beats forwarded bit-exact; `pitch.data={0x000012345678, 6'd9}`; `busy` falls one cycle after the pitch handshake.
- Products equal and maximal at k=3 and k=10 → `pitch` bin = 5.
- Second frame starts while EMIT is held by `pitch.ready=0` → the whole frame is discarded; `hps_out.valid` stays 0; `frames_dropped=1`. The third frame is forwarded.
- `enable` rises at beat 500 of a frame → beats 500–1023 are discarded with `frames_dropped=0`; the next frame start is forwarded.
- `hps_out.ready` toggles randomly at 50% → `fft_in.ready` mirrors it; the HPS receives exactly 1024 beats in order; the pitch result matches the reference model.
- `reset_n` pulsed low at PASS beat 300 → all outputs take their reset values asynchronously; the next frame after release is forwarded from beat 0.

Source files
------------

// File: rtl/hps_pitch_scheduler.sv
// Frame-level gate in front of harmonic_product_spectrum: admits whole frames while idle,
// drops frames that arrive while busy, and reduces the HPS products to one pitch result.
module hps_pitch_scheduler #(
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned PRODUCT_WIDTH = 48,
    parameter int unsigned FRAME_LEN     = 1024,
    parameter int unsigned NUM_HPS       = 32,
    parameter int unsigned BIN_OFFSET    = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,

    input  logic                       fft_in_valid,
    output logic                       fft_in_ready,
    input  logic [DATA_WIDTH-1:0]      fft_in_data,

    output logic                       hps_out_valid,
    input  logic                       hps_out_ready,
    output logic [DATA_WIDTH-1:0]      hps_out_data,

    input  logic                       hps_in_valid,
    output logic                       hps_in_ready,
    input  logic [PRODUCT_WIDTH-1:0]   hps_in_data,

    output logic                       pitch_valid,
    input  logic                       pitch_ready,
    output logic [PRODUCT_WIDTH+5:0]   pitch_data,

    output logic                       busy,
    output logic [15:0]                frames_dropped
);

    localparam int unsigned CntW = $clog2(FRAME_LEN);
    localparam int unsigned KW   = $clog2(NUM_HPS);

    typedef enum logic [1:0] {StIdle, StPass, StCollect, StEmit} state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          in_count_q;
    logic [KW-1:0]            k_q;
    logic [PRODUCT_WIDTH-1:0] max_val_q;
    logic [KW-1:0]            max_idx_q;
    logic [15:0]              drop_q;

    logic frame_start, fwd_beat, forwarding;
    logic fft_hs, hps_hs, pitch_hs;
    logic last_beat, last_k;
    logic [5:0] bin;

    assign frame_start = (in_count_q == '0);
    // Admission needs a real frame-start beat while idle; otherwise the beat is swallowed.
    assign fwd_beat    = (state_q == StIdle) && frame_start && enable && fft_in_valid;
    assign forwarding  = fwd_beat || (state_q == StPass);
    assign fft_hs      = fft_in_valid && fft_in_ready;
    assign hps_hs      = hps_in_valid && hps_in_ready;
    assign pitch_hs    = pitch_valid && pitch_ready;
    assign last_beat   = (in_count_q == CntW'(FRAME_LEN - 1));
    assign last_k      = (k_q == KW'(NUM_HPS - 1));
    assign bin         = 6'(max_idx_q) + 6'(BIN_OFFSET);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (fwd_beat && hps_out_ready) state_d = StPass;
            StPass:    if (fft_hs && last_beat)       state_d = StCollect;
            StCollect: if (hps_hs && last_k)          state_d = StEmit;
            StEmit:    if (pitch_hs)                  state_d = StIdle;
            default:                                  state_d = StIdle;
        endcase
    end

    always_comb begin
        fft_in_ready   = forwarding ? hps_out_ready : 1'b1;
        hps_out_valid  = forwarding ? fft_in_valid : 1'b0;
        hps_out_data   = fft_in_data;
        hps_in_ready   = (state_q == StCollect);
        pitch_valid    = (state_q == StEmit);
        pitch_data     = {max_val_q, bin};
        busy           = (state_q != StIdle);
        frames_dropped = drop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_count_q <= '0;
            k_q        <= '0;
            max_val_q  <= '0;
            max_idx_q  <= '0;
            drop_q     <= '0;
        end else begin
            if (fft_hs) begin
                in_count_q <= in_count_q + 1'b1;
            end
            if (hps_hs) begin
                k_q <= last_k ? '0 : k_q + 1'b1;
                // Strict compare so ties keep the lower bin.
                if (k_q == '0) begin
                    max_val_q <= hps_in_data;
                    max_idx_q <= '0;
                end else if (hps_in_data > max_val_q) begin
                    max_val_q <= hps_in_data;
                    max_idx_q <= k_q;
                end
            end
            if ((state_q == StCollect || state_q == StEmit) && fft_hs && frame_start && enable
                && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

endmodule
